// File: rtl/comparador_serie_if.sv
// comparador_serie_if: start/operand request and busy/done/eq/gt/lt result bundle
interface comparador_serie_if #(parameter int W = 8);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;
    modport master (output start, a, b, input busy, done, eq, gt, lt);
    modport slave (input start, a, b, output busy, done, eq, gt, lt);
endinterface

// File: rtl/comparador_serie.sv
// comparador_serie: bit-serial MSB-first unsigned comparator over the comparador1 cell.
// Define COMPARADOR_EARLY_EXIT_EN to leave SHIFT right after the first differing bit.
module comparador1 (
    input  logic a,
    input  logic b,
    output logic eq
);
    assign eq = a ~^ b;
endmodule

module comparador_serie #(
    parameter int W = 8
) (
    input logic               clk,
    input logic               rst,
    comparador_serie_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  sa, sb;
    logic [CW-1:0] cnt;
    logic          dec, gt_r, eq_q, gt_q, lt_q;
    logic          bit_eq, dec_n, gt_n, fin, load;

    comparador1 u_cell (.a(sa[W-1]), .b(sb[W-1]), .eq(bit_eq));

    // The first mismatch decides the result; its A bit tells which side is larger
    assign dec_n = dec | ~bit_eq;
    assign gt_n  = (!dec && !bit_eq) ? sa[W-1] : gt_r;
    assign load  = (state != SHIFT) && bus.start;

`ifdef COMPARADOR_EARLY_EXIT_EN
    assign fin = (cnt == CW'(1)) || dec_n;
`else
    assign fin = cnt == CW'(1);
`endif

    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state: IDLE and DONE both accept start, SHIFT runs until fin
    always_comb begin
        state_n = state;
        state_n = (state == SHIFT) ? (fin ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
    end

    // Operand capture, serial shifting and result registration on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
            dec  <= 1'b0;
            gt_r <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (load) begin
            sa   <= bus.a;
            sb   <= bus.b;
            cnt  <= CW'(W);
            dec  <= 1'b0;
            gt_r <= 1'b0;
        end else if (state == SHIFT) begin
            sa   <= sa << 1;
            sb   <= sb << 1;
            cnt  <= cnt - CW'(1);
            dec  <= dec_n;
            gt_r <= gt_n;
            if (fin) begin
                eq_q <= !dec_n;
                gt_q <= dec_n & gt_n;
                lt_q <= dec_n & !gt_n;
            end
        end
    end
endmodule
